// File: rtl/obi_mailbox_fifo.sv
// -----------------------------------------------------------------------------
// obi_mailbox_fifo
//
// DEPTH-deep mailbox FIFO between two OBI-style slave ports. The writer port
// pushes words and the reader port pops them. Each port also exposes a
// read-only STATUS image. Address bit 2 selects the register: 0 = DATA,
// 1 = STATUS.
//
// STATUS image: [15:0] count, [16] full, [17] empty, [18] OVF, [19] UNF.
// The image is truncated to DATA_WIDTH.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   writer_*             writer OBI port (req/gnt/rvalid/addr/we/be/wdata/rdata)
//                        - DATA write pushes a word; disabled bytes are stored
//                          as 0x00.
//                        - STATUS write: bit0 = flush, bit1 = clear OVF/UNF.
//   reader_*             reader OBI port, same shape as the writer port
//                        - DATA read pops a word.
//                        - STATUS write: bit1 = clear OVF/UNF.
//   irq_o                level interrupt, asserted while count >= IRQ_THRESHOLD
//
// gnt is combinational. rvalid/rdata follow one cycle after gnt, and rdata
// is zero whenever rvalid is low.
// -----------------------------------------------------------------------------
module obi_mailbox_fifo #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DEPTH          = 4,
    parameter bit          BLOCK_ON_FULL  = 1'b1,
    parameter bit          BLOCK_ON_EMPTY = 1'b1,
    parameter int unsigned IRQ_THRESHOLD  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    writer_req_i,
    output logic                    writer_gnt_o,
    output logic                    writer_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   writer_addr_i,
    input  logic                    writer_we_i,
    input  logic [DATA_WIDTH/8-1:0] writer_be_i,
    input  logic [DATA_WIDTH-1:0]   writer_wdata_i,
    output logic [DATA_WIDTH-1:0]   writer_rdata_o,

    input  logic                    reader_req_i,
    output logic                    reader_gnt_o,
    output logic                    reader_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   reader_addr_i,
    input  logic                    reader_we_i,
    input  logic [DATA_WIDTH/8-1:0] reader_be_i,
    input  logic [DATA_WIDTH-1:0]   reader_wdata_i,
    output logic [DATA_WIDTH-1:0]   reader_rdata_o,

    output logic                    irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] IRQ_C   = CNT_W'(IRQ_THRESHOLD);

    // Disabled byte lanes are forced to zero rather than keeping stale data.
    function automatic logic [DATA_WIDTH-1:0] mask_bytes(
        input logic [DATA_WIDTH-1:0] d,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] status_image(
        input logic [CNT_W-1:0] cnt,
        input logic             f,
        input logic             e,
        input logic             o,
        input logic             u
    );
        logic [31:0] s;
        s             = '0;
        s[CNT_W-1:0]  = cnt;
        s[16]         = f;
        s[17]         = e;
        s[18]         = o;
        s[19]         = u;
        return s[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  ovf;
    logic                  unf;
    logic                  full;
    logic                  empty;

    logic                  w_status;
    logic                  r_status;
    logic                  push_req;
    logic                  pop_req;
    logic                  do_push;
    logic                  do_pop;
    logic                  flush;
    logic                  flag_clr;
    logic                  ovf_set;
    logic                  unf_set;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] w_rdata_p0;
    logic [DATA_WIDTH-1:0] r_rdata_p0;

    logic                  writer_rvalid_p1;
    logic                  reader_rvalid_p1;
    logic [DATA_WIDTH-1:0] writer_rdata_p1;
    logic [DATA_WIDTH-1:0] reader_rdata_p1;

    // Only addr[2], reader wdata[1] and writer wdata[1:0] on STATUS matter;
    // the rest of these inputs are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{writer_addr_i, reader_addr_i, reader_be_i, reader_wdata_i};

    // ---- p0: request decode, grant and FIFO update ----
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign w_status = writer_addr_i[2];
    assign r_status = reader_addr_i[2];
    assign status   = status_image(count, full, empty, ovf, unf);

    assign writer_gnt_o = writer_req_i &
                          ~(writer_we_i & ~w_status & full & BLOCK_ON_FULL);
    assign reader_gnt_o = reader_req_i &
                          ~(~reader_we_i & ~r_status & empty & BLOCK_ON_EMPTY);

    assign push_req = writer_gnt_o & writer_we_i & ~w_status;
    assign pop_req  = reader_gnt_o & ~reader_we_i & ~r_status;
    assign flush    = writer_gnt_o & writer_we_i & w_status & writer_wdata_i[0];
    assign flag_clr = (writer_gnt_o & writer_we_i & w_status & writer_wdata_i[1]) |
                      (reader_gnt_o & reader_we_i & r_status & reader_wdata_i[1]);
    // Only reachable in non-blocking modes; blocking modes never grant these.
    assign ovf_set  = push_req & full;
    assign unf_set  = pop_req & empty;
    // Flush wins over a push in the same cycle; a pop still returns the old head.
    assign do_push  = push_req & ~full & ~flush;
    assign do_pop   = pop_req & ~empty;

    assign w_rdata_p0 = (writer_gnt_o & ~writer_we_i & w_status) ? status : '0;

    always_comb begin
        r_rdata_p0 = '0;
        if (reader_gnt_o && !reader_we_i) begin
            if (r_status)    r_rdata_p0 = status;
            else if (do_pop) r_rdata_p0 = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            // A set in the same cycle as a clear takes priority.
            if (ovf_set)       ovf <= 1'b1;
            else if (flag_clr) ovf <= 1'b0;
            if (unf_set)       unf <= 1'b1;
            else if (flag_clr) unf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= mask_bytes(writer_wdata_i, writer_be_i);
    end

    // ---- p1: registered responses ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            writer_rvalid_p1 <= 1'b0;
            reader_rvalid_p1 <= 1'b0;
            writer_rdata_p1  <= '0;
            reader_rdata_p1  <= '0;
        end else begin
            writer_rvalid_p1 <= writer_gnt_o;
            reader_rvalid_p1 <= reader_gnt_o;
            writer_rdata_p1  <= w_rdata_p0;
            reader_rdata_p1  <= r_rdata_p0;
        end
    end

    assign writer_rvalid_o = writer_rvalid_p1;
    assign reader_rvalid_o = reader_rvalid_p1;
    assign writer_rdata_o  = writer_rdata_p1;
    assign reader_rdata_o  = reader_rdata_p1;
    assign irq_o           = (count >= IRQ_C);

endmodule

// File: tb/tb_obi_mailbox_fifo.sv
// Bench for obi_mailbox_fifo: one blocking instance (index 0) and one
// non-blocking instance (index 1) share the stimulus; "cur" selects which
// one is modelled and checked.
module tb_obi_mailbox_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        w_req, w_we, r_req, r_we;
    logic [31:0] w_addr, w_wdata, r_addr, r_wdata;
    logic [3:0]  w_be, r_be;

    logic        wg_o [2];
    logic        wv_o [2];
    logic        rg_o [2];
    logic        rv_o [2];
    logic        irq_v [2];
    logic [31:0] wd_o [2];
    logic [31:0] rd_o [2];

    bit          cur;
    logic        w_gnt, r_gnt, w_rvalid, r_rvalid, irq;
    logic [31:0] w_rdata, r_rdata;
    assign w_gnt    = cur ? wg_o[1]  : wg_o[0];
    assign r_gnt    = cur ? rg_o[1]  : rg_o[0];
    assign w_rvalid = cur ? wv_o[1]  : wv_o[0];
    assign r_rvalid = cur ? rv_o[1]  : rv_o[0];
    assign w_rdata  = cur ? wd_o[1]  : wd_o[0];
    assign r_rdata  = cur ? rd_o[1]  : rd_o[0];
    assign irq      = cur ? irq_v[1] : irq_v[0];

    obi_mailbox_fifo #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4),
        .BLOCK_ON_FULL(1'b1), .BLOCK_ON_EMPTY(1'b1), .IRQ_THRESHOLD(2)
    ) dut_blk (
        .clk_i(clk), .rst_ni(rst_n),
        .writer_req_i(w_req), .writer_gnt_o(wg_o[0]), .writer_rvalid_o(wv_o[0]),
        .writer_addr_i(w_addr), .writer_we_i(w_we), .writer_be_i(w_be),
        .writer_wdata_i(w_wdata), .writer_rdata_o(wd_o[0]),
        .reader_req_i(r_req), .reader_gnt_o(rg_o[0]), .reader_rvalid_o(rv_o[0]),
        .reader_addr_i(r_addr), .reader_we_i(r_we), .reader_be_i(r_be),
        .reader_wdata_i(r_wdata), .reader_rdata_o(rd_o[0]),
        .irq_o(irq_v[0])
    );

    obi_mailbox_fifo #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4),
        .BLOCK_ON_FULL(1'b0), .BLOCK_ON_EMPTY(1'b0), .IRQ_THRESHOLD(2)
    ) dut_nb (
        .clk_i(clk), .rst_ni(rst_n),
        .writer_req_i(w_req), .writer_gnt_o(wg_o[1]), .writer_rvalid_o(wv_o[1]),
        .writer_addr_i(w_addr), .writer_we_i(w_we), .writer_be_i(w_be),
        .writer_wdata_i(w_wdata), .writer_rdata_o(wd_o[1]),
        .reader_req_i(r_req), .reader_gnt_o(rg_o[1]), .reader_rvalid_o(rv_o[1]),
        .reader_addr_i(r_addr), .reader_we_i(r_we), .reader_be_i(r_be),
        .reader_wdata_i(r_wdata), .reader_rdata_o(rd_o[1]),
        .irq_o(irq_v[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: a queue of words plus sticky flags and the expected
    // one-cycle-late responses.
    logic [31:0] q[$];
    logic        m_ovf, m_unf, m_wv, m_rv;
    logic [31:0] m_wd, m_rd;

    function automatic logic [31:0] bmask(input logic [31:0] d, input logic [3:0] be);
        return {be[3] ? d[31:24] : 8'h00, be[2] ? d[23:16] : 8'h00,
                be[1] ? d[15:8]  : 8'h00, be[0] ? d[7:0]   : 8'h00};
    endfunction

    function automatic logic [31:0] stat_word();
        return {12'h000, m_unf, m_ovf, q.size() == 0, q.size() == 4, 16'(q.size())};
    endfunction

    function automatic logic exp_wgnt();
        return w_req && !(w_we && !w_addr[2] && q.size() == 4 && cur == 1'b0);
    endfunction

    function automatic logic exp_rgnt();
        return r_req && !(!r_we && !r_addr[2] && q.size() == 0 && cur == 1'b0);
    endfunction

    function automatic logic [31:0] mk_addr(input bit st);
        logic [31:0] a;
        a      = $urandom;
        a[2]   = st;
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_run();
        logic full, empty, wg, rg, push, pop, flush, clr;
        logic [31:0] st;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_ovf = 0; m_unf = 0; m_wv = 0; m_rv = 0; m_wd = 0; m_rd = 0;
            end else begin
                full  = (q.size() == 4);
                empty = (q.size() == 0);
                st    = stat_word();
                wg    = exp_wgnt();
                rg    = exp_rgnt();
                m_wv  = wg;
                m_wd  = (wg && !w_we && w_addr[2]) ? st : 32'h0;
                m_rv  = rg;
                m_rd  = 32'h0;
                if (rg && !r_we) m_rd = r_addr[2] ? st : (empty ? 32'h0 : q[0]);
                push  = wg && w_we && !w_addr[2];
                pop   = rg && !r_we && !r_addr[2];
                flush = wg && w_we && w_addr[2] && w_wdata[0];
                clr   = (wg && w_we && w_addr[2] && w_wdata[1]) ||
                        (rg && r_we && r_addr[2] && r_wdata[1]);
                if (clr) begin m_ovf = 0; m_unf = 0; end
                if (push && full) m_ovf = 1;
                if (pop && empty) m_unf = 1;
                if (pop && !empty) void'(q.pop_front());
                if (push && !full) q.push_back(bmask(w_wdata, w_be));
                if (flush) q.delete();
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_w_rvalid", w_rvalid, 1'b0);
                chk1("rst_r_rvalid", r_rvalid, 1'b0);
                chk("rst_w_rdata", w_rdata, 32'h0);
                chk("rst_r_rdata", r_rdata, 32'h0);
                chk1("rst_irq", irq, 1'b0);
            end else begin
                chk1("w_gnt", w_gnt, exp_wgnt());
                chk1("r_gnt", r_gnt, exp_rgnt());
                chk1("w_rvalid", w_rvalid, m_wv);
                chk1("r_rvalid", r_rvalid, m_rv);
                chk("w_rdata", w_rdata, m_wd);
                chk("r_rdata", r_rdata, m_rd);
                chk1("irq", irq, q.size() >= 2);
            end
        end
    endtask

    // One transfer on either port, held until granted, returning rdata.
    task automatic xfer(input bit port, input bit we, input bit st,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd);
        int n;
        logic g;
        if (!port) begin
            w_req = 1; w_we = we; w_addr = mk_addr(st); w_wdata = wd; w_be = be;
        end else begin
            r_req = 1; r_we = we; r_addr = mk_addr(st); r_wdata = wd; r_be = be;
        end
        n = 0;
        forever begin
            #1;
            g = port ? r_gnt : w_gnt;
            @(posedge clk);
            #1;
            if (g) break;
            n++;
            if (n > 30) begin
                n_checks++;
                n_errors++;
                $display("FAIL xfer_timeout: port %0d no grant within 30 cycles", port);
                break;
            end
        end
        if (!port) w_req = 0; else r_req = 0;
        #1;
        rd = port ? r_rdata : w_rdata;
    endtask

    task automatic push(input logic [31:0] v);
        logic [31:0] d;
        xfer(1'b0, 1'b1, 1'b0, v, 4'hF, d);
    endtask

    task automatic pop(output logic [31:0] v);
        xfer(1'b1, 1'b0, 1'b0, 32'h0, 4'hF, v);
    endtask

    // Writer write (DATA or STATUS) and reader pop in the same cycle.
    task automatic dual(input bit wst, input logic [31:0] wd, output logic [31:0] rrd);
        w_req = 1; w_we = 1; w_addr = mk_addr(wst); w_wdata = wd; w_be = 4'hF;
        r_req = 1; r_we = 0; r_addr = mk_addr(1'b0);
        #1;
        chk1("dual_w_gnt", w_gnt, 1'b1);
        chk1("dual_r_gnt", r_gnt, 1'b1);
        @(posedge clk);
        #1;
        w_req = 0; r_req = 0;
        #1;
        rrd = r_rdata;
    endtask

    task automatic rand_phase(input int n, input int push_bias);
        logic wgs, rgs;
        wgs = 0; rgs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!(w_req && !wgs)) begin
                w_req   = ($urandom_range(0, 3) != 0);
                w_we    = ($urandom_range(0, 9) < push_bias);
                w_addr  = mk_addr($urandom_range(0, 9) == 0);
                w_wdata = $urandom;
                if (w_addr[2]) w_wdata[0] = ($urandom_range(0, 15) == 0);
                w_be    = 4'($urandom);
            end
            if (!(r_req && !rgs)) begin
                r_req   = ($urandom_range(0, 3) != 0);
                r_we    = ($urandom_range(0, 7) == 0);
                r_addr  = mk_addr($urandom_range(0, 9) == 0);
                r_wdata = $urandom;
                r_be    = 4'($urandom);
            end
            @(negedge clk);
            wgs = w_gnt;
            rgs = r_gnt;
        end
        @(posedge clk);
        #1;
        w_req = 0; r_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        w_req = 0; w_we = 0; w_addr = 0; w_wdata = 0; w_be = 0;
        r_req = 0; r_we = 0; r_addr = 0; r_wdata = 0; r_be = 0;
        cur = 1'b0;
        fork
            model_run();
            monitor();
        join_none

        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk1("reset_w_rvalid", w_rvalid, 1'b0);
        chk1("reset_irq", irq, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("reset_status", v, 32'h0002_0000);

        // Basic order and irq threshold
        push(32'h11); chk1("irq_after_1", irq, 1'b0);
        push(32'h22); chk1("irq_after_2", irq, 1'b1);
        push(32'h33);
        pop(v); chk("pop_11", v, 32'h11); chk1("irq_cnt2", irq, 1'b1);
        pop(v); chk("pop_22", v, 32'h22); chk1("irq_cnt1", irq, 1'b0);
        pop(v); chk("pop_33", v, 32'h33);

        // Byte enables
        xfer(1'b0, 1'b1, 1'b0, 32'hAABBCCDD, 4'b0101, v);
        pop(v); chk("be_mask", v, 32'h00BB00DD);

        // Blocking full
        push(32'h1); push(32'h2); push(32'h3); push(32'h4);
        xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("full_status", v, 32'h0001_0004);
        fork
            push(32'h5);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk1("full_hold_gnt", w_gnt, 1'b0);
                end
                pop(v);
                chk("pop_while_full", v, 32'h1);
            end
        join
        pop(v); chk("after_full_2", v, 32'h2);
        pop(v); chk("after_full_3", v, 32'h3);
        pop(v); chk("after_full_4", v, 32'h4);
        pop(v); chk("after_full_5", v, 32'h5);

        // Simultaneous push/pop with pointer wrap
        push(32'h40); push(32'h41);
        for (int i = 0; i < 10; i++) begin
            dual(1'b0, 32'h42 + 32'(i), v);
            chk("wrap_order", v, 32'h40 + 32'(i));
        end
        xfer(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("wrap_status", v, 32'h0000_0002);

        // Flush concurrent with pop
        push(32'h99);
        dual(1'b1, 32'h1, v);
        chk("flush_pop_head", v, 32'h4A);
        xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("flush_status", v, 32'h0002_0000);
        chk1("flush_irq", irq, 1'b0);

        // Reset in the middle of a pop
        push(32'h77);
        @(posedge clk);
        #1;
        r_req = 1; r_we = 0; r_addr = mk_addr(1'b0);
        #2;
        rst_n = 0; r_req = 0;
        repeat (3) begin
            @(negedge clk);
            chk1("midrst_rvalid", r_rvalid, 1'b0);
            chk("midrst_rdata", r_rdata, 32'h0);
            chk1("midrst_gnt", r_gnt, 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("midrst_status", v, 32'h0002_0000);

        rand_phase(1500, 7);
        rand_phase(1500, 4);

        // Non-blocking instance
        rst_n = 0;
        cur = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 1; i <= 5; i++) push(32'(i));
        xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("nb_ovf_status", v, 32'h0005_0004);
        for (int i = 1; i <= 4; i++) begin
            pop(v);
            chk("nb_pop", v, 32'(i));
        end
        pop(v); chk("nb_pop_empty", v, 32'h0);
        xfer(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("nb_unf_status", v, 32'h000E_0000);
        xfer(1'b1, 1'b1, 1'b1, 32'h2, 4'hF, v);
        xfer(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, v);
        chk("nb_clear_status", v, 32'h0002_0000);

        rand_phase(1500, 7);
        rand_phase(1500, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obi_mailbox_fifo.md
Name: obi_mailbox_fifo

Overview:
- Parametrised multi-entry mailbox between two OBI-style slave ports: a writer port that pushes words and a reader port that pops them.
- Generalises the single-word full/empty handoff register to a DEPTH-deep circular FIFO.
- Adds byte enables, a status word on each port, full/empty policies, flush, sticky error flags and a threshold interrupt.
- Sits in the MCU peripheral domain as a producer/consumer channel between two bus masters (e.g. serial link and core).

Parameters:
- DATA_WIDTH, 32, data word width; a multiple of 8, ≤32.
- ADDR_WIDTH, 32, address width of both ports.
- DEPTH, 4, FIFO entries; power of 2, 2..32768.
- BLOCK_ON_FULL, 1, 1: withhold writer gnt while full; 0: grant, drop word, set OVF.
- BLOCK_ON_EMPTY, 1, 1: withhold reader gnt while empty; 0: grant, return 0, set UNF.
- IRQ_THRESHOLD, 1, irq_o asserted while count ≥ this value; range 1..DEPTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- writer_req_i  in  1  writer request
- writer_gnt_o  out  1  writer grant (combinational)
- writer_rvalid_o  out  1  writer response valid
- writer_addr_i  in  ADDR_WIDTH  writer address; bit 2 selects register
- writer_we_i  in  1  writer write enable
- writer_be_i  in  DATA_WIDTH/8  writer byte enables
- writer_wdata_i  in  DATA_WIDTH  writer write data
- writer_rdata_o  out  DATA_WIDTH  writer read data
- reader_req_i, reader_gnt_o, reader_rvalid_o, reader_addr_i, reader_we_i, reader_be_i, reader_wdata_i, reader_rdata_o: same widths and directions as the writer port, for the reader side.
- irq_o  out  1  threshold interrupt (level)

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and count of $clog2(DEPTH)+1 bits.
- full = (count == DEPTH); empty = (count == 0). Both are derived from registered count only.
- Register map, both ports, addr[2]:
  - 0: DATA.
  - 1: STATUS, read-only image: [15:0] count, [16] full, [17] empty, [18] OVF, [19] UNF; other bits 0. Bits above DATA_WIDTH are truncated.
- Grant rules:
  - gnt = req in the same cycle, except writer DATA write with full & BLOCK_ON_FULL=1, and reader DATA read with empty & BLOCK_ON_EMPTY=1; in both cases gnt=0 until the condition clears.
  - A requester holds req/addr/we/wdata until granted.
- Response: every granted transfer produces rvalid=1 exactly one cycle after gnt. rdata is registered and valid only with rvalid; it is 0 otherwise and for all writes.
- Writer port:
  - DATA write: push at wr_ptr. Bytes with be=0 are stored as 0x00.
  - DATA read: returns 0, no effect.
  - STATUS write: wdata[0]=1 flushes (ptrs=0, count=0); wdata[1]=1 clears OVF/UNF.
  - STATUS read: status image.
- Reader port:
  - DATA read: pop; rdata = mem[rd_ptr].
  - DATA write: granted, ignored.
  - STATUS write: wdata[1]=1 clears OVF/UNF; wdata[0] is ignored.
  - STATUS read: status image.
- Non-blocking modes:
  - Push when full: granted, data dropped, OVF set.
  - Pop when empty: granted, rdata=0 on rvalid, UNF set.
  - OVF/UNF are sticky until cleared.
- Simultaneous events in one cycle:
  - Push+pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Push while empty with pop request: push proceeds; pop follows the empty rule (not granted when blocking).
  - Pop while full with push request: pop proceeds; push follows the full rule.
  - Flush+pop: pop returns the pre-flush head, then count=0.
  - Flush+any push that cycle: flush wins, FIFO empty afterwards.
  - Flag-set and flag-clear together: set wins.
- irq_o = (count ≥ IRQ_THRESHOLD), driven from registered count; rises the cycle after the push that reaches the threshold.
- Reset values: count=0, ptrs=0, OVF=UNF=0, rvalid=0, rdata=0, irq_o=0. gnt is 0 while req=0. Memory contents are not reset.
- Reset mid-transfer: pending rvalid is dropped and FIFO contents are discarded.

Test Plan:
- DEPTH=4, IRQ_THRESHOLD=2; push 0x11,0x22,0x33 then pop x3 -> rdata 0x11,0x22,0x33, each on rvalid one cycle after gnt; irq_o rises after the 2nd push and falls when count drops to 1.
- Push 0xAABBCCDD with be=4'b0101 then pop -> rdata 0x00BB00DD.
- BLOCK_ON_FULL=1: 4 pushes, then a 5th held 3 cycles -> writer_gnt_o=0 until a pop; 5th granted the cycle after the pop; STATUS count=4, full=1.
- BLOCK_ON_FULL=0, BLOCK_ON_EMPTY=0: 5 pushes -> STATUS = 0x0005_0004 (OVF+full, count 4). Pop 5 times -> 5th rdata=0 and UNF set. Reader STATUS write 0x2 -> OVF/UNF cleared.
- With count=2, same-cycle push 0x44 and pop -> count stays 2, pointers wrap correctly over 10 iterations, data order preserved.
- With count=3, writer STATUS write 0x1 concurrent with pop -> pop returns old head; next cycle STATUS empty=1, count=0, irq_o=0. Assert rst_ni mid-pop -> rvalid never asserted, all outputs 0.
